// File: rtl/banana_collector.sv
// banana_collector
//   Per-level banana pickup tracker. Every rising edge of frame_clk (while
//   active is high) starts a scan that walks the five entries of the banana
//   position ROM, compares each banana against a snapshot of the player
//   position and latches a sticky collected bit for every banana in reach.
//   The collected map is published on banana_bits once the scan is complete.
//
// Ports
//   Clk            system clock
//   Reset_n        asynchronous active-low reset
//   frame_clk      frame tick (synchronous to Clk); its rising edge starts a scan
//   level_restart  synchronous clear of all collected bits, aborts any scan
//   active         gates scan start only (pause / death)
//   player_x/y     player centre position
//   rom_idx        banana index presented to the position ROM (0..4)
//   banana_x/y     ROM data, valid one cycle after rom_idx
//   banana_bits    published collected map, bit i = banana i collected
//   collect_pulse  one-cycle pulse per newly collected banana
//   all_collected  high while banana_bits == 5'b11111
//   scan_busy      high while a scan is in progress (FSM not IDLE)
module banana_collector #(
    parameter int HIT_W   = 16,
    parameter int HIT_H   = 16,
    parameter int COORD_W = 10
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_clk,
    input  logic               level_restart,
    input  logic               active,
    input  logic [COORD_W-1:0] player_x,
    input  logic [COORD_W-1:0] player_y,
    output logic [2:0]         rom_idx,
    input  logic [COORD_W-1:0] banana_x,
    input  logic [COORD_W-1:0] banana_y,
    output logic [4:0]         banana_bits,
    output logic               collect_pulse,
    output logic               all_collected,
    output logic               scan_busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_COMPARE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [2:0]       LAST_IDX = 3'd4;
    localparam logic [COORD_W:0] HIT_W_L  = (COORD_W+1)'(HIT_W);
    localparam logic [COORD_W:0] HIT_H_L  = (COORD_W+1)'(HIT_H);

    logic [1:0]         state;
    logic               frame_clk_d;
    logic               frame_edge;
    logic [COORD_W-1:0] px_s;
    logic [COORD_W-1:0] py_s;
    logic [4:0]         collected;
    logic [4:0]         idx_mask;
    logic [COORD_W:0]   dx;
    logic [COORD_W:0]   dy;
    logic               hit;

    assign frame_edge = frame_clk & ~frame_clk_d;
    assign scan_busy  = (state != ST_IDLE);

    // rom_idx doubles as the scan index: it is stable through FETCH and
    // COMPARE, so the ROM data seen in COMPARE belongs to this banana.
    assign idx_mask = 5'b00001 << rom_idx;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        dx  = '0;
        dy  = '0;
        hit = 1'b0;
        // Subtract the smaller from the larger so the distance never wraps.
        if (px_s >= banana_x) dx = {1'b0, px_s} - {1'b0, banana_x};
        else                  dx = {1'b0, banana_x} - {1'b0, px_s};
        if (py_s >= banana_y) dy = {1'b0, py_s} - {1'b0, banana_y};
        else                  dy = {1'b0, banana_y} - {1'b0, py_s};
        // Strict compare: a distance equal to the half-window is a miss.
        hit = (dx < HIT_W_L) && (dy < HIT_H_L) && ((collected & idx_mask) == 5'b0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= ST_IDLE;
            frame_clk_d   <= 1'b0;
            px_s          <= '0;
            py_s          <= '0;
            rom_idx       <= '0;
            collected     <= '0;
            banana_bits   <= '0;
            all_collected <= 1'b0;
            collect_pulse <= 1'b0;
        end else begin
            frame_clk_d   <= frame_clk;
            collect_pulse <= 1'b0;
            if (level_restart) begin
                // Restart outranks everything, including a coincident frame edge.
                state         <= ST_IDLE;
                rom_idx       <= '0;
                collected     <= '0;
                banana_bits   <= '0;
                all_collected <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (frame_edge && active) begin
                            px_s    <= player_x;
                            py_s    <= player_y;
                            rom_idx <= '0;
                            state   <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        state <= ST_COMPARE;
                    end
                    ST_COMPARE: begin
                        if (hit) begin
                            collected     <= collected | idx_mask;
                            collect_pulse <= 1'b1;
                        end
                        if (rom_idx == LAST_IDX) begin
                            state <= ST_DONE;
                        end else begin
                            rom_idx <= rom_idx + 3'd1;
                            state   <= ST_FETCH;
                        end
                    end
                    ST_DONE: begin
                        banana_bits   <= collected;
                        all_collected <= (collected == 5'b11111);
                        state         <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
